instr_fetch_unit: RTL and testbench

//  Program-counter and fetch sequencer that sits between the CPU execute stage and the

---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Program-counter and fetch sequencer between the execute stage and a synchronous
// instruction ROM. It presents the PC as the ROM address and waits out the ROM read
// latency. It then captures the instruction, resolves JMP and HALT locally, and offers
// every other instruction to execute over a valid/ready handshake.
module instr_fetch_unit #(
   parameter int          ADDR_W      = 4,
   parameter int          DATA_W      = 8,
   parameter int          ROM_LATENCY = 1,
   parameter int          RESET_PC    = 0,
   parameter logic [3:0]  OPC_JMP     = 4'hE,
   parameter logic [3:0]  OPC_HALT    = 4'hF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [3:0]        opcode,
   output logic [3:0]        operand,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              branch_req,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              halted,
   output logic [7:0]        fetch_count
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FETCH  = 2'd1;
   localparam logic [1:0] ISSUE  = 2'd2;
   localparam logic [1:0] HALTED = 2'd3;

   // Wait counter spans ROM_LATENCY+2 edges; the last value marks the capture edge.
   localparam int          CNT_W    = (ROM_LATENCY + 2 > 2) ? $clog2(ROM_LATENCY + 2) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LATENCY + 1);
   // When the address was already driven on the previous edge (accept or JMP), the
   // ROM sees it one edge earlier, so the wait starts one step in.
   localparam logic [CNT_W-1:0] CNT_REDIRECT = CNT_W'(1);

   logic [1:0]        state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] next_pc_s;
   logic [3:0]        cap_opcode_s;
   logic [3:0]        cap_operand_s;

   // Split the ROM word and compute the PC that follows an accepted instruction.
   always_comb begin
      cap_opcode_s  = rom_data[DATA_W-1 -: 4];
      cap_operand_s = rom_data[3:0];
      if (branch_req) begin
         next_pc_s = branch_target;
      end else begin
         next_pc_s = pc_r + ADDR_W'(1);
      end
   end

   // Fetch FSM: address generation, latency wait, capture/decode and issue handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         pc_r        <= ADDR_W'(RESET_PC);
         rom_addr    <= ADDR_W'(RESET_PC);
         instr_valid <= 1'b0;
         opcode      <= 4'h0;
         operand     <= 4'h0;
         pc_out      <= '0;
         halted      <= 1'b0;
         fetch_count <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r  <= FETCH;
                  rom_addr <= pc_r;
                  cnt_r    <= '0;
               end
            end
            FETCH: begin
               if (cnt_r == CNT_LAST) begin
                  if (cap_opcode_s == OPC_JMP) begin
                     // Jump resolved locally; a jump to itself simply refetches forever.
                     pc_r     <= ADDR_W'(cap_operand_s);
                     rom_addr <= ADDR_W'(cap_operand_s);
                     cnt_r    <= CNT_REDIRECT;
                  end else if (cap_opcode_s == OPC_HALT) begin
                     state_r <= HALTED;
                     halted  <= 1'b1;
                  end else begin
                     opcode      <= cap_opcode_s;
                     operand     <= cap_operand_s;
                     pc_out      <= pc_r;
                     instr_valid <= 1'b1;
                     state_r     <= ISSUE;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ISSUE: begin
               if (instr_ready) begin
                  if (fetch_count != 8'hFF) begin
                     fetch_count <= fetch_count + 8'h01;
                  end
                  pc_r        <= next_pc_s;
                  rom_addr    <= next_pc_s;
                  instr_valid <= 1'b0;
                  cnt_r       <= CNT_REDIRECT;
                  state_r     <= FETCH;
               end
            end
            HALTED: begin
               state_r <= HALTED;
            end
            default: begin
               state_r     <= IDLE;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural one-cycle synchronous ROM.
module tb_instr_fetch_unit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] opcode;
   logic [3:0] operand;
   logic [3:0] pc_out;
   logic       branch_req;
   logic [3:0] branch_target;
   logic       halted;
   logic [7:0] fetch_count;

   int n_cmp;
   int n_err;

   logic [7:0] rom [16];

   typedef struct {
      logic [3:0] pc;
      logic [3:0] opc;
      logic [3:0] opd;
      int         stall;
      logic       br;
      logic [3:0] tgt;
      logic [3:0] nxt;
      logic [7:0] cnt;
   } vec_t;

   vec_t vec [32];
   int   nv;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
      .operand(operand), .pc_out(pc_out), .branch_req(branch_req),
      .branch_target(branch_target), .halted(halted), .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: samples the address on each rising edge.
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] pc, input logic [3:0] opc, input logic [3:0] opd,
                      input int stall, input logic br, input logic [3:0] tgt,
                      input logic [3:0] nxt, input logic [7:0] cnt);
      vec[nv].pc = pc; vec[nv].opc = opc; vec[nv].opd = opd; vec[nv].stall = stall;
      vec[nv].br = br; vec[nv].tgt = tgt; vec[nv].nxt = nxt; vec[nv].cnt = cnt;
      nv++;
   endtask

   // Apply table entries lo..hi: wait for the offer, check it, stall, accept, check.
   task automatic run_entries(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         for (int w = 0; w < 12 && !instr_valid; w++) step();
         chk("offer_valid", {31'd0, instr_valid}, 32'd1);
         chk("pc_out", {28'd0, pc_out}, {28'd0, vec[i].pc});
         chk("opcode", {28'd0, opcode}, {28'd0, vec[i].opc});
         chk("operand", {28'd0, operand}, {28'd0, vec[i].opd});
         for (int s = 0; s < vec[i].stall; s++) begin
            branch_req = 1'b1;          // must be ignored while not accepting
            branch_target = 4'h7;
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_opcode", {28'd0, opcode}, {28'd0, vec[i].opc});
            chk("stall_operand", {28'd0, operand}, {28'd0, vec[i].opd});
            chk("stall_count", {24'd0, fetch_count}, {24'd0, vec[i].cnt - 8'd1});
         end
         instr_ready = 1'b1;
         branch_req = vec[i].br;
         branch_target = vec[i].tgt;
         step();
         instr_ready = 1'b0;
         branch_req = 1'b0;
         chk("accept_valid", {31'd0, instr_valid}, 32'd0);
         chk("next_rom_addr", {28'd0, rom_addr}, {28'd0, vec[i].nxt});
         chk("fetch_count", {24'd0, fetch_count}, {24'd0, vec[i].cnt});
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; nv = 0;
      rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
      branch_req = 1'b0; branch_target = 4'h0;

      rom[0] = 8'h30; rom[1] = 8'h11; rom[2] = 8'h22; rom[3] = 8'h6B;
      for (int p = 4; p <= 10; p++) rom[p] = 8'h40 + 8'(p);
      rom[11] = 8'hE0; rom[12] = 8'hFF; rom[13] = 8'h00; rom[14] = 8'h00; rom[15] = 8'h30;

      // First loop over 1..10 (entry pc3 stalls five cycles).
      add(4'h1, 4'h1, 4'h1, 0, 1'b0, 4'h0, 4'h2, 8'd2);
      add(4'h2, 4'h2, 4'h2, 0, 1'b0, 4'h0, 4'h3, 8'd3);
      add(4'h3, 4'h6, 4'hB, 5, 1'b0, 4'h0, 4'h4, 8'd4);
      for (int p = 4; p <= 10; p++)
         add(4'(p), 4'h4, 4'(p), 0, 1'b0, 4'h0, 4'(p + 1), 8'(p + 1));
      // Second loop after JMP 0; branch to C on the accept of address 10.
      add(4'h0, 4'h3, 4'h0, 0, 1'b0, 4'h0, 4'h1, 8'd12);
      add(4'h1, 4'h1, 4'h1, 0, 1'b0, 4'h0, 4'h2, 8'd13);
      add(4'h2, 4'h2, 4'h2, 0, 1'b0, 4'h0, 4'h3, 8'd14);
      add(4'h3, 4'h6, 4'hB, 0, 1'b0, 4'h0, 4'h4, 8'd15);
      for (int p = 4; p <= 9; p++)
         add(4'(p), 4'h4, 4'(p), 0, 1'b0, 4'h0, 4'(p + 1), 8'(p + 12));
      add(4'hA, 4'h4, 4'hA, 0, 1'b1, 4'hC, 4'hC, 8'd22);
      // After reset: branch to F, then wrap to 0.
      add(4'h0, 4'h3, 4'h0, 0, 1'b1, 4'hF, 4'hF, 8'd1);
      add(4'hF, 4'h3, 4'h0, 0, 1'b0, 4'h0, 4'h0, 8'd2);

      #12;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
      chk("rst_count", {24'd0, fetch_count}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      rst_n = 1'b1;
      step();
      step();
      chk("idle_valid", {31'd0, instr_valid}, 32'd0);

      // First fetch: start sampled at E0, offer visible after E3.
      start = 1'b1; instr_ready = 1'b1;
      step();
      start = 1'b0;
      chk("e0_rom_addr", {28'd0, rom_addr}, 32'd0);
      chk("e0_valid", {31'd0, instr_valid}, 32'd0);
      step();
      chk("e1_valid", {31'd0, instr_valid}, 32'd0);
      step();
      chk("e2_valid", {31'd0, instr_valid}, 32'd0);
      step();
      chk("e3_valid", {31'd0, instr_valid}, 32'd1);
      chk("e3_opcode", {28'd0, opcode}, 32'd3);
      chk("e3_operand", {28'd0, operand}, 32'd0);
      chk("e3_pc_out", {28'd0, pc_out}, 32'd0);
      step();
      instr_ready = 1'b0;
      chk("e4_valid", {31'd0, instr_valid}, 32'd0);
      chk("e4_rom_addr", {28'd0, rom_addr}, 32'd1);
      chk("e4_count", {24'd0, fetch_count}, 32'd1);

      run_entries(0, 20);

      // HALT at C: terminal, everything else ignored.
      for (int w = 0; w < 12 && !halted; w++) step();
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halt_rom_addr", {28'd0, rom_addr}, 32'hC);
      start = 1'b1; instr_ready = 1'b1; branch_req = 1'b1; branch_target = 4'h2;
      for (int c = 0; c < 20; c++) begin
         step();
         chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      end
      chk("halt_hold_addr", {28'd0, rom_addr}, 32'hC);
      chk("halt_hold_count", {24'd0, fetch_count}, 32'd22);
      chk("halt_hold_flag", {31'd0, halted}, 32'd1);
      start = 1'b0; instr_ready = 1'b0; branch_req = 1'b0;

      // Asynchronous reset while halted takes effect without a clock edge.
      rst_n = 1'b0;
      #1;
      chk("arst_halted", {31'd0, halted}, 32'd0);
      chk("arst_count", {24'd0, fetch_count}, 32'd0);
      chk("arst_rom_addr", {28'd0, rom_addr}, 32'd0);
      #3;
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      run_entries(21, 22);

      // Reset in the middle of an issue abandons the offer.
      for (int w = 0; w < 12 && !instr_valid; w++) step();
      chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
      chk("pre_rst_opcode", {28'd0, opcode}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("mid_rst_opcode", {28'd0, opcode}, 32'd0);
      chk("mid_rst_count", {24'd0, fetch_count}, 32'd0);
      chk("mid_rst_pc_out", {28'd0, pc_out}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
